multicycle_control_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32I-subset datapath (Program_Counter, Instruction_Memory,

---
 rtl/multicycle_control_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the RV32I-subset datapath: FETCH/DECODE/EXEC/MEM/WB with
// bounded memory handshakes, a retired-instruction counter and a sticky HALT on errors.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic [6:0]       i_opcode,
    input  logic             i_alu_zero,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    output logic             o_imem_req,
    output logic             o_dmem_req,
    output logic             o_ir_write,
    output logic             o_pc_write,
    output logic             o_pc_branch,
    output logic             o_reg_write,
    output logic             o_alu_src,
    output logic [1:0]       o_alu_op,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_mem_to_reg,
    output logic             o_halted,
    output logic [1:0]       o_err_code,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH
    } iclass_t;

    state_t           r_state, w_next;
    iclass_t          r_class, w_class;
    logic [7:0]       r_wait, w_wait;
    logic [1:0]       r_err, w_err;
    logic [CNT_W-1:0] r_retired;
    logic             w_retire;

    logic       r_imem_req, r_dmem_req, r_branch_exec, r_reg_write, r_alu_src;
    logic       r_mem_read, r_mem_write, r_mem_to_reg, r_halted;
    logic [1:0] r_alu_op, r_err_out;
    logic       w_imem_req, w_dmem_req, w_branch_exec, w_reg_write, w_alu_src;
    logic       w_mem_read, w_mem_write, w_mem_to_reg, w_halted;
    logic [1:0] w_alu_op, w_err_out;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_class       <= C_R;
            r_wait        <= '0;
            r_err         <= '0;
            r_retired     <= '0;
            r_imem_req    <= 1'b0;
            r_dmem_req    <= 1'b0;
            r_branch_exec <= 1'b0;
            r_reg_write   <= 1'b0;
            r_alu_src     <= 1'b0;
            r_alu_op      <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_halted      <= 1'b0;
            r_err_out     <= '0;
        end else begin
            r_state       <= w_next;
            r_class       <= w_class;
            r_wait        <= w_wait;
            r_err         <= w_err;
            r_retired     <= w_retire ? r_retired + CNT_W'(1) : r_retired;
            r_imem_req    <= w_imem_req;
            r_dmem_req    <= w_dmem_req;
            r_branch_exec <= w_branch_exec;
            r_reg_write   <= w_reg_write;
            r_alu_src     <= w_alu_src;
            r_alu_op      <= w_alu_op;
            r_mem_read    <= w_mem_read;
            r_mem_write   <= w_mem_write;
            r_mem_to_reg  <= w_mem_to_reg;
            r_halted      <= w_halted;
            r_err_out     <= w_err_out;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_class  = r_class;
        w_wait   = r_wait;
        w_err    = r_err;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) begin
                    w_next = S_FETCH;
                    w_wait = '0;
                end
            end
            S_FETCH: begin
                if (i_imem_ready) begin
                    w_next = S_DECODE;
                end else if (r_wait == 8'(MEM_TIMEOUT - 1)) begin
                    w_next = S_HALT;
                    w_err  = 2'b10;
                end else begin
                    w_wait = r_wait + 8'd1;
                end
            end
            S_DECODE: begin
                w_next = S_EXEC;
                case (i_opcode)
                    7'b0110011: w_class = C_R;
                    7'b0010011: w_class = C_I;
                    7'b0000011: w_class = C_LOAD;
                    7'b0100011: w_class = C_STORE;
                    7'b1100011: w_class = C_BRANCH;
                    default: begin
                        w_next = S_HALT;
                        w_err  = 2'b01;
                    end
                endcase
            end
            S_EXEC: begin
                w_wait = '0;
                case (r_class)
                    C_BRANCH: begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    C_LOAD, C_STORE: w_next = S_MEM;
                    default:         w_next = S_WB;
                endcase
            end
            S_MEM: begin
                if (i_dmem_ready) begin
                    if (r_class == C_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_FETCH;
                        w_wait   = '0;
                        w_retire = 1'b1;
                    end
                end else if (r_wait == 8'(MEM_TIMEOUT - 1)) begin
                    w_next = S_HALT;
                    w_err  = 2'b11;
                end else begin
                    w_wait = r_wait + 8'd1;
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                w_wait   = '0;
                w_retire = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase

        // Outputs are decoded from the state being entered so they line up with it.
        w_imem_req    = (w_next == S_FETCH);
        w_dmem_req    = (w_next == S_MEM);
        w_mem_read    = (w_next == S_MEM) && (w_class == C_LOAD);
        w_mem_write   = (w_next == S_MEM) && (w_class == C_STORE);
        w_branch_exec = (w_next == S_EXEC) && (w_class == C_BRANCH);
        w_alu_src     = (w_next == S_EXEC) && (w_class != C_R) && (w_class != C_BRANCH);
        w_alu_op      = 2'b00;
        if (w_next == S_EXEC) begin
            if (w_class == C_R || w_class == C_I) begin
                w_alu_op = 2'b10;
            end else if (w_class == C_BRANCH) begin
                w_alu_op = 2'b01;
            end
        end
        w_reg_write   = (w_next == S_WB);
        w_mem_to_reg  = (w_next == S_WB) && (w_class == C_LOAD);
        w_halted      = (w_next == S_HALT);
        w_err_out     = (w_next == S_HALT) ? w_err : 2'b00;
    end

    // Completion strobes qualify the registered state flag with the handshake seen this cycle.
    assign o_ir_write   = r_imem_req & i_imem_ready;
    assign o_pc_write   = r_imem_req & i_imem_ready;
    assign o_pc_branch  = r_branch_exec & i_alu_zero;
    assign o_imem_req   = r_imem_req;
    assign o_dmem_req   = r_dmem_req;
    assign o_reg_write  = r_reg_write;
    assign o_alu_src    = r_alu_src;
    assign o_alu_op     = r_alu_op;
    assign o_mem_read   = r_mem_read;
    assign o_mem_write  = r_mem_write;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_halted     = r_halted;
    assign o_err_code   = r_err_out;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level model expands each instruction into
// its expected per-cycle output trace, driven with randomized waits, flags and don't-care inputs.
module tb_multicycle_control_fsm;

    localparam int TO = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic run = 1'b0;
    logic [6:0] opcode = '0;
    logic aluZero = 1'b0;
    logic imemReady = 1'b0;
    logic dmemReady = 1'b0;

    logic imemReq, dmemReq, irWrite, pcWrite, pcBranch, regWrite, aluSrc;
    logic memRead, memWrite, memToReg, halted;
    logic [1:0] aluOp, errCode;
    logic [CW-1:0] retired;

    multicycle_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(resetN), .i_run(run), .i_opcode(opcode),
        .i_alu_zero(aluZero), .i_imem_ready(imemReady), .i_dmem_ready(dmemReady),
        .o_imem_req(imemReq), .o_dmem_req(dmemReq), .o_ir_write(irWrite),
        .o_pc_write(pcWrite), .o_pc_branch(pcBranch), .o_reg_write(regWrite),
        .o_alu_src(aluSrc), .o_alu_op(aluOp), .o_mem_read(memRead),
        .o_mem_write(memWrite), .o_mem_to_reg(memToReg), .o_halted(halted),
        .o_err_code(errCode), .o_retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic imemReq; logic dmemReq; logic irWrite; logic pcWrite; logic pcBranch;
        logic regWrite; logic aluSrc; logic [1:0] aluOp; logic memRead; logic memWrite;
        logic memToReg; logic halted; logic [1:0] errCode; logic [CW-1:0] retired;
    } outVec_t;

    typedef struct {
        outVec_t exp; logic run; logic [6:0] op; logic imemRdy; logic dmemRdy; logic zero;
        string tag;
    } step_t;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011;

    int vectors = 0;
    int miscompares = 0;
    int modelRetired = 0;
    logic [6:0] curOp = '0;
    step_t plan[$];
    logic [6:0] opTable [5];

    function automatic outVec_t observe();
        return {imemReq, dmemReq, irWrite, pcWrite, pcBranch, regWrite, aluSrc, aluOp,
                memRead, memWrite, memToReg, halted, errCode, retired};
    endfunction

    // Default cycle: every output idle, irrelevant inputs randomized.
    function automatic step_t mkStep(string tag);
        step_t s;
        s.exp = '0;
        s.exp.retired = CW'(modelRetired);
        s.run = 1'($urandom_range(0, 1));
        s.op = curOp;
        s.imemRdy = 1'($urandom_range(0, 1));
        s.dmemRdy = 1'($urandom_range(0, 1));
        s.zero = 1'($urandom_range(0, 1));
        s.tag = tag;
        return s;
    endfunction

    task automatic pushIdle(input bit go);
        step_t s;
        s = mkStep("idle");
        s.run = go;
        plan.push_back(s);
    endtask

    task automatic planHalt(input logic [1:0] err, input int n);
        step_t s;
        for (int i = 0; i < n; i++) begin
            s = mkStep("halt");
            s.exp.halted = 1'b1;
            s.exp.errCode = err;
            plan.push_back(s);
        end
    endtask

    // fw/mw = wait cycles before ready; a value >= TO means ready never arrives.
    task automatic planInstr(input logic [6:0] op, input int fw, input int mw, input bit zero);
        step_t s;
        bit isR, isI, isLd, isSt, isBr;
        curOp = op;
        for (int i = 0; i < fw && i < TO; i++) begin
            s = mkStep("fetchWait");
            s.exp.imemReq = 1'b1;
            s.imemRdy = 1'b0;
            plan.push_back(s);
        end
        if (fw >= TO) begin
            planHalt(2'b10, 3);
            return;
        end
        s = mkStep("fetchDone");
        s.exp.imemReq = 1'b1; s.exp.irWrite = 1'b1; s.exp.pcWrite = 1'b1;
        s.imemRdy = 1'b1;
        plan.push_back(s);
        plan.push_back(mkStep("decode"));
        isR = (op == OP_R); isI = (op == OP_I); isLd = (op == OP_LD);
        isSt = (op == OP_ST); isBr = (op == OP_BR);
        if (!(isR || isI || isLd || isSt || isBr)) begin
            planHalt(2'b01, 4);
            return;
        end
        s = mkStep("exec");
        s.exp.aluSrc = isI || isLd || isSt;
        s.exp.aluOp = (isR || isI) ? 2'b10 : (isBr ? 2'b01 : 2'b00);
        if (isBr) begin
            s.zero = zero;
            s.exp.pcBranch = zero;
            plan.push_back(s);
            modelRetired++;
            return;
        end
        plan.push_back(s);
        if (isLd || isSt) begin
            for (int i = 0; i < mw && i < TO; i++) begin
                s = mkStep("memWait");
                s.exp.dmemReq = 1'b1; s.exp.memRead = isLd; s.exp.memWrite = isSt;
                s.dmemRdy = 1'b0;
                plan.push_back(s);
            end
            if (mw >= TO) begin
                planHalt(2'b11, 3);
                return;
            end
            s = mkStep("memDone");
            s.exp.dmemReq = 1'b1; s.exp.memRead = isLd; s.exp.memWrite = isSt;
            s.dmemRdy = 1'b1;
            plan.push_back(s);
            if (isSt) begin
                modelRetired++;
                return;
            end
        end
        s = mkStep("wb");
        s.exp.regWrite = 1'b1;
        s.exp.memToReg = isLd;
        plan.push_back(s);
        modelRetired++;
    endtask

    task automatic applyStimulus();
        step_t s;
        outVec_t obs;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge clk);
            run = s.run; opcode = s.op; imemReady = s.imemRdy;
            dmemReady = s.dmemRdy; aluZero = s.zero;
            #1;
            obs = observe();
            vectors++;
            assert (obs === s.exp) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed=%h expected=%h", s.tag, obs, s.exp);
            end
        end
    endtask

    task automatic checkOutput(input string tag, input outVec_t expv);
        outVec_t obs;
        obs = observe();
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        resetN = 1'b0;
        run = 1'b1;
        imemReady = 1'b1;
        dmemReady = 1'b1;
        @(negedge clk);
        run = 1'b0;
        #1;
        checkOutput("reset", '0);
        resetN = 1'b1;
        modelRetired = 0;
    endtask

    initial begin
        opTable[0] = OP_R; opTable[1] = OP_I; opTable[2] = OP_LD;
        opTable[3] = OP_ST; opTable[4] = OP_BR;

        doReset();
        pushIdle(1'b0);
        pushIdle(1'b1);
        planInstr(OP_R, 0, 0, 1'b0);
        planInstr(OP_LD, 0, 3, 1'b0);
        planInstr(OP_BR, 0, 0, 1'b1);
        planInstr(OP_BR, 0, 0, 1'b0);
        planInstr(OP_ST, 1, 0, 1'b0);
        planInstr(OP_I, 3, 2, 1'b0);
        applyStimulus();

        for (int n = 0; n < 40; n++) begin
            planInstr(opTable[$urandom_range(0, 4)], $urandom_range(0, TO - 1),
                      $urandom_range(0, TO - 1), 1'($urandom_range(0, 1)));
            applyStimulus();
        end

        // Reset lands while a load is still waiting on data memory.
        planInstr(OP_LD, 0, 3, 1'b0);
        void'(plan.pop_back());
        void'(plan.pop_back());
        void'(plan.pop_back());
        applyStimulus();
        doReset();
        pushIdle(1'b1);
        planInstr(OP_R, 0, 0, 1'b0);
        planInstr(7'b1111111, 0, 0, 1'b0);
        applyStimulus();

        doReset();
        pushIdle(1'b1);
        planInstr(OP_R, TO, 0, 1'b0);
        applyStimulus();

        doReset();
        pushIdle(1'b1);
        planInstr(OP_ST, 0, TO, 1'b0);
        applyStimulus();

        doReset();
        pushIdle(1'b0);
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
